deser8: RTL

Serial-to-parallel collector that rebuilds an 8-bit word from a bit stream.
- Bit i of the word arrives while the bit index equals i, counting 0→7, LSB first.
- This is the inverse of the 8:1 mux path, where y = d[s] with s stepping 0..7.
- It sits at the receive end of the serial link and hands each completed word to downstream logic over a one-entry valid/ready output register.

---
 rtl/deser8.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/deser8.sv
`timescale 1ns/1ps
// deser8: rebuilds an 8-bit word from a serial bit stream, LSB first, and
// hands completed words downstream through a one-entry valid/ready register.
// A partial word is discarded after TIMEOUT idle cycles (0 disables this).
// Optional feature macro DESER8_PARITY_EN: after bit 7 one more bit carrying
// even parity is expected; a mismatch still delivers the word and pulses par_err.
module deser8 #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  output logic [2:0] idx,
  output logic [7:0] d_out,
  output logic       d_valid,
  input  logic       d_ready,
  output logic       overrun,
  output logic       timeout,
  output logic       par_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The timeout fires on the idle edge that brings the count to TIMEOUT,
  // so the stored count never exceeds TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d, shift_wr;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      dout_q, dout_d;
  logic            dvld_q, dvld_d;
  logic            ovr_q, ovr_d;
  logic            tmo_q, tmo_d;
  logic            tmo_hit;
  logic            word_done;
  logic [7:0]      word_val;

  assign tmo_hit = (TIMEOUT > 0) && (state_q != S_IDLE) && !din_valid && (cnt_q == CNT_LAST);

`ifdef DESER8_PARITY_EN
  logic perr_q, perr_d;
  logic par_bad;
  assign word_done = din_valid && (state_q == S_PARITY);
  assign word_val  = shift_q;
  assign par_bad   = din != (^shift_q);
  assign perr_d    = word_done && par_bad;
  assign par_err   = perr_q;
`else
  assign word_done = din_valid && (state_q == S_SHIFT) && (idx_q == 3'd7);
  assign word_val  = shift_wr;
  assign par_err   = 1'b0;
`endif

  assign idx     = idx_q;
  assign d_out   = dout_q;
  assign d_valid = dvld_q;
  assign overrun = ovr_q;
  assign timeout = tmo_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start on the first bit, finish after bit 7 (or the parity bit), abandon on timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (din_valid) state_d = S_SHIFT;
      S_SHIFT: begin
        if (din_valid) begin
`ifdef DESER8_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_IDLE;
`endif
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
`ifdef DESER8_PARITY_EN
      S_PARITY: if (din_valid || tmo_hit) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register with the incoming bit written at the current index.
  always_comb begin
    shift_wr         = shift_q;
    shift_wr[idx_q]  = din;
  end

  // Datapath next-state: bit capture, idle counter, output register and pulses.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q;
    ovr_d   = 1'b0;
    tmo_d   = 1'b0;

    if (din_valid && (state_q != S_PARITY)) begin
      shift_d = shift_wr;
      idx_d   = idx_q + 3'd1;
    end

    if ((state_q == S_IDLE) || din_valid) begin
      cnt_d = '0;
    end else if (tmo_hit) begin
      cnt_d   = '0;
      idx_d   = 3'd0;
      shift_d = '0;
      tmo_d   = 1'b1;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (dvld_q && d_ready) dvld_d = 1'b0;

    // A completed word takes the slot if it is empty or draining now; otherwise it is lost.
    if (word_done) begin
      if (!dvld_q || d_ready) begin
        dout_d = word_val;
        dvld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      cnt_q   <= '0;
      dout_q  <= 8'h00;
      dvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef DESER8_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
`ifdef DESER8_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

endmodule
